// File: rtl/cmp_sequencer.sv
// rtl/cmp_sequencer.sv - debounced-button magnitude compare sequencer with RGB result and saturating tallies
//
// Ports:
//   CLK100MHZ  in   system clock, sole clock domain
//   BTNC       in   synchronous active-high reset
//   BTNU       in   raw compare-request button (asynchronous)
//   SW         in   operands: A = SW[WIDTH-1:0], B = SW[2*WIDTH-1:WIDTH]
//   LED16_R    out  lit during SHOW when A == B
//   LED16_B    out  lit during SHOW when A > B
//   LED16_G    out  lit during SHOW when A < B
//   LED        out  {lt_tally, eq_tally, gt_tally}, gt_tally in the LSBs
//   busy       out  high whenever the sequencer is not idle
module cmp_sequencer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 100000000,
    parameter int TALLY_W         = 4
) (
    input  logic                   CLK100MHZ,
    input  logic                   BTNC,
    input  logic                   BTNU,
    input  logic [2*WIDTH-1:0]     SW,
    output logic                   LED16_R,
    output logic                   LED16_B,
    output logic                   LED16_G,
    output logic [3*TALLY_W-1:0]   LED,
    output logic                   busy
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DB_W-1:0]    DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]    DB_FIRE   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_COMPARE,
        S_SHOW
    } state_t;

    state_t state;
    state_t state_n;

    // Two-flop synchronizer for the raw button.
    logic btn_m;
    logic btn_s;

    // sync_fill[1] is set once btn_s holds a sample taken after reset; until
    // then btn_s is just the cleared reset value and says nothing about the pin.
    logic [1:0] sync_fill;

    // A button held through reset must be seen released before it may fire,
    // otherwise the reset press itself would immediately start a compare.
    logic armed;

    logic [DB_W-1:0] db_cnt;
    logic            press_pulse;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               res_gt;
    logic               res_eq;
    logic               res_lt;
    logic [TALLY_W-1:0] gt_tally;
    logic [TALLY_W-1:0] eq_tally;
    logic [TALLY_W-1:0] lt_tally;
    logic [HOLD_W-1:0]  hold_cnt;

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            btn_m     <= 1'b0;
            btn_s     <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            btn_m     <= BTNU;
            btn_s     <= btn_m;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            armed <= 1'b0;
        end else if (sync_fill[1] && !btn_s) begin
            armed <= 1'b1;
        end
    end

    // Counter saturates so a long hold yields a single pulse; it runs in every
    // state, so a press that matured while busy is already spent on return to idle.
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC || !btn_s) begin
            db_cnt <= '0;
        end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign press_pulse = btn_s && armed && (db_cnt == DB_FIRE);

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (press_pulse) state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_COMPARE;
            S_COMPARE: state_n = S_SHOW;
            S_SHOW:    if (hold_cnt == '0) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            a_q      <= '0;
            b_q      <= '0;
            res_gt   <= 1'b0;
            res_eq   <= 1'b0;
            res_lt   <= 1'b0;
            gt_tally <= '0;
            eq_tally <= '0;
            lt_tally <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_CAPTURE: begin
                    a_q <= SW[WIDTH-1:0];
                    b_q <= SW[2*WIDTH-1:WIDTH];
                end
                S_COMPARE: begin
                    res_gt   <= (a_q > b_q);
                    res_eq   <= (a_q == b_q);
                    res_lt   <= (a_q < b_q);
                    hold_cnt <= HOLD_LOAD;
                    if (a_q > b_q) begin
                        if (gt_tally != TALLY_MAX) gt_tally <= gt_tally + 1'b1;
                    end else if (a_q == b_q) begin
                        if (eq_tally != TALLY_MAX) eq_tally <= eq_tally + 1'b1;
                    end else begin
                        if (lt_tally != TALLY_MAX) lt_tally <= lt_tally + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // The result flags are one-hot by construction, so gating with the state
    // keeps the RGB outputs mutually exclusive and dark outside SHOW.
    assign LED16_R = (state == S_SHOW) && res_eq;
    assign LED16_B = (state == S_SHOW) && res_gt;
    assign LED16_G = (state == S_SHOW) && res_lt;
    assign LED     = {lt_tally, eq_tally, gt_tally};
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_cmp_sequencer.sv
// tb/tb_cmp_sequencer.sv - randomized scoreboard bench for cmp_sequencer
module tb_cmp_sequencer;

    localparam int WIDTH = 2;
    localparam int DB    = 4;
    localparam int HOLD  = 8;
    localparam int TW    = 4;

    logic        clk = 1'b0;
    logic        BTNC;
    logic        BTNU;
    logic [3:0]  SW;
    logic        led_r;
    logic        led_b;
    logic        led_g;
    logic [11:0] led;
    logic        busy;

    always #5 clk = ~clk;

    cmp_sequencer #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HOLD),
        .TALLY_W(TW)
    ) dut (
        .CLK100MHZ(clk),
        .BTNC(BTNC),
        .BTNU(BTNU),
        .SW(SW),
        .LED16_R(led_r),
        .LED16_B(led_b),
        .LED16_G(led_g),
        .LED(led),
        .busy(busy)
    );

    typedef struct packed {
        logic [2:0]  rgb;
        logic [11:0] led;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   gt_t, eq_t, lt_t;
    int   shows_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Reference: {R,B,G} = {A==B, A>B, A<B}; tallies saturate at 15.
    task automatic model_push(input int a, input int b);
        exp_t e;
        if (a > b)       gt_t = (gt_t < 15) ? gt_t + 1 : 15;
        else if (a == b) eq_t = (eq_t < 15) ? eq_t + 1 : 15;
        else             lt_t = (lt_t < 15) ? lt_t + 1 : 15;
        e.rgb = (a == b) ? 3'b100 : (a > b) ? 3'b010 : 3'b001;
        e.led = {lt_t[3:0], eq_t[3:0], gt_t[3:0]};
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        BTNC = 1'b1;
        repeat (n) tick();
        BTNC = 1'b0;
        gt_t = 0;
        eq_t = 0;
        lt_t = 0;
        sb_q.delete();
    endtask

    task automatic wait_show(output bit ok);
        int t;
        t = 0;
        ok = 1'b0;
        while (t < 40) begin
            @(negedge clk);
            if ({led_r, led_b, led_g} != 3'b000) begin
                ok = 1'b1;
                break;
            end
            t++;
        end
        if (!ok) fail_now("show_timeout");
    endtask

    task automatic wait_idle_scramble();
        int t;
        t = 0;
        while (busy && t < 40) begin
            tick();
            SW = 4'($urandom);
            t++;
        end
        if (busy) fail_now("idle_timeout");
        repeat (3) tick();
    endtask

    task automatic do_compare(input int a, input int b, input int hold, input bit second_press);
        bit ok;
        model_push(a, b);
        SW   = {2'(b), 2'(a)};
        BTNU = 1'b1;
        repeat (hold) tick();
        BTNU = 1'b0;
        wait_show(ok);
        if (ok && second_press) begin
            tick();
            BTNU = 1'b1;
            repeat (5) begin
                tick();
                SW = 4'($urandom);
            end
            BTNU = 1'b0;
        end
        wait_idle_scramble();
    endtask

    // Monitor: each SHOW onset pops one expectation; the run length and
    // steadiness of the colour are checked until it goes dark.
    logic       in_show = 1'b0;
    logic       aborted = 1'b0;
    int         show_len = 0;
    logic [2:0] cur_rgb;
    logic [2:0] rgb_now;
    exp_t       mon_e;

    always @(negedge clk) begin
        rgb_now = {led_r, led_b, led_g};
        if (in_show && rgb_now == 3'b000) begin
            if (!aborted) check("show_len", show_len, HOLD);
            in_show = 1'b0;
        end else if (in_show) begin
            show_len++;
            check("rgb_steady", {29'd0, rgb_now}, {29'd0, cur_rgb});
        end else if (rgb_now != 3'b000) begin
            shows_seen++;
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_compare: got rgb %b expected none", rgb_now);
            end else begin
                mon_e = sb_q.pop_front();
                check("rgb", {29'd0, rgb_now}, {29'd0, mon_e.rgb});
                check("tally_led", {20'd0, led}, {20'd0, mon_e.led});
            end
            in_show  = 1'b1;
            aborted  = 1'b0;
            show_len = 1;
            cur_rgb  = rgb_now;
        end
        if (rgb_now != 3'b000) check("rgb_onehot", $countones(rgb_now), 1);
        if (BTNC) aborted = 1'b1;
    end

    int  order[16];
    int  tmp;
    int  j;
    int  seen_busy;
    int  shows_before;
    int  v;
    bit  ok;

    initial begin
        BTNC = 1'b0;
        BTNU = 1'b0;
        SW   = 4'd0;
        gt_t = 0;
        eq_t = 0;
        lt_t = 0;

        // Reset state
        do_reset(2);
        @(negedge clk);
        check("reset_led", {20'd0, led}, 32'd0);
        check("reset_rgb", {29'd0, led_r, led_b, led_g}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Press held through reset must not fire until released and re-pressed
        BTNU = 1'b1;
        tick();
        do_reset(2);
        seen_busy = 0;
        repeat (20) begin
            tick();
            if (busy) seen_busy++;
        end
        check("held_through_reset", seen_busy, 0);
        BTNU = 1'b0;
        repeat (3) tick();
        do_compare(1, 2, 5, 1'b0);

        // All 16 operand pairs in random order
        do_reset(2);
        repeat (3) tick();
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 16; i++) begin
            do_compare(order[i] % 4, order[i] / 4, $urandom_range(7, 4), 1'b0);
        end
        check("pair_tallies", {20'd0, led}, 32'h646);

        // Glitchy press: 3 high, 1 low, 3 high never reaches the threshold
        seen_busy = 0;
        BTNU = 1'b1;
        repeat (3) begin tick(); if (busy) seen_busy++; end
        BTNU = 1'b0;
        tick();
        if (busy) seen_busy++;
        BTNU = 1'b1;
        repeat (3) begin tick(); if (busy) seen_busy++; end
        BTNU = 1'b0;
        repeat (10) begin tick(); if (busy) seen_busy++; end
        check("glitch_no_compare", seen_busy, 0);

        // Long press: exactly one compare
        shows_before = shows_seen;
        do_compare(3, 1, 10, 1'b0);
        seen_busy = 0;
        repeat (15) begin tick(); if (busy) seen_busy++; end
        check("long_press_single", shows_seen - shows_before, 1);
        check("long_press_no_refire", seen_busy, 0);

        // Second press and SW change during SHOW are ignored
        shows_before = shows_seen;
        do_compare(2, 0, 5, 1'b1);
        seen_busy = 0;
        repeat (15) begin tick(); if (busy) seen_busy++; end
        check("busy_drop_single", shows_seen - shows_before, 1);
        check("busy_drop_idle", seen_busy, 0);
        check("busy_drop_tally", {20'd0, led}, {20'd0, lt_t[3:0], eq_t[3:0], gt_t[3:0]});

        // Saturation of eq tally
        do_reset(2);
        repeat (3) tick();
        for (int i = 0; i < 17; i++) begin
            v = $urandom_range(3, 0);
            do_compare(v, v, $urandom_range(7, 4), 1'b0);
        end
        check("eq_saturation", {20'd0, led}, 32'h0F0);

        // A few extra random compares
        for (int i = 0; i < 6; i++) begin
            do_compare($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(7, 4), 1'b0);
        end

        // Reset at SHOW cycle 3
        model_push(0, 3);
        SW   = 4'b1100;
        BTNU = 1'b1;
        repeat (5) tick();
        BTNU = 1'b0;
        wait_show(ok);
        tick();
        tick();
        BTNC = 1'b1;
        tick();
        @(negedge clk);
        check("midshow_rst_rgb", {29'd0, led_r, led_b, led_g}, 32'd0);
        check("midshow_rst_led", {20'd0, led}, 32'd0);
        check("midshow_rst_busy", {31'd0, busy}, 32'd0);
        BTNC = 1'b0;
        gt_t = 0;
        eq_t = 0;
        lt_t = 0;
        repeat (5) tick();

        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
